inst_decode_stage: RTL and testbench
====================================

Name: inst_decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage that sits between fetch and register-read.
- Splits each fetched instruction word into opcode, register, shamt, funct, immediate and jump-address fields.
- Generalises field widths, adds sign/zero-extended immediates and R-type classification, and carries the PC alongside.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure never combinationally reaches fetch.
- Supports a synchronous flush for branch redirects.

Parameters:
INST_W, 32, instruction word width
OPC_W, 6, opcode field width (top bits of word)
REG_W, 5, width of each of rd/rs/rt fields
SHAMT_W, 5, shift-amount field width
FUNCT_W, 6, funct field width (bottom bits of word)
DATA_W, 32, width of extended immediate outputs (DATA_W >= IMM_W)
PC_W, 32, program counter width
RTYPE_OPC, 6'h00, opcode value classified as R-type

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  discard all held instructions
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage can accept
in_inst  in  INST_W  instruction word
in_pc  in  PC_W  PC of in_inst
out_valid  out  1  decoded instruction available
out_ready  in  1  downstream accepts
out_pc  out  PC_W  PC of decoded instruction
opecode  out  OPC_W  inst[INST_W-1 -: OPC_W]
rd  out  REG_W  next REG_W bits below opcode
rs  out  REG_W  next REG_W bits below rd
rt  out  REG_W  next REG_W bits below rs
shamt  out  SHAMT_W  inst[FUNCT_W +: SHAMT_W]
funct  out  FUNCT_W  inst[FUNCT_W-1:0]
immd  out  IMM_W  inst[IMM_W-1:0], IMM_W = INST_W-OPC_W-2*REG_W
imm_sext  out  DATA_W  immd sign-extended
imm_zext  out  DATA_W  immd zero-extended
addr  out  INST_W-OPC_W  inst[INST_W-OPC_W-1:0]
is_rtype  out  1  opecode == RTYPE_OPC

Behaviour:
- Width legality: OPC_W+3*REG_W+SHAMT_W+FUNCT_W must equal INST_W. An illegal combination is an elaboration error (generate-time check).
- Storage: output register (main) plus one skid register. Each holds a valid bit, the instruction word and the PC.
- Field outputs are pure slices/extensions of the main register's stored word. There is no decode logic after the register beyond these slices.
- Reset (async, rst=1):
  - main and skid valid = 0, so out_valid=0.
  - in_ready=1 after reset deasserts.
  - Data registers and all field outputs = 0.
- in_ready = !skid_valid. It is registered, with no combinational path from out_ready.
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- Per-cycle update when flush=0:
  - main empty or delivered: main loads skid if skid_valid, else the accepted input, else goes empty.
  - If skid supplied main and an input is accepted the same cycle, that input goes to skid.
  - main full and not delivered: an accepted input goes to skid (skid was empty, else in_ready=0).
- Latency: an accepted instruction appears on out_valid the next cycle when main is empty or being drained and skid is empty.
- Ordering: strict FIFO. Full throughput is 1 instr/cycle while out_ready=1.
- Stability: while out_valid=1 and out_ready=0, every output is held constant.
- flush=1:
  - Next cycle main and skid valid = 0. The input offered that cycle is dropped even if in_ready=1.
  - Data registers may keep stale contents.
  - flush has priority over accept and deliver.
  - in_ready=1 the cycle after flush.
- Reset mid-stream: held instructions are lost immediately; out_valid falls asynchronously.

Test Plan:
- Basic decode: in_inst=0x28611020, in_pc=0x100, out_ready=1. Next cycle:
  - out_valid=1, opecode=0x0A, rd=3, rs=1, rt=2, shamt=0, funct=0x20.
  - immd=0x1020, addr=0x0611020, is_rtype=0, out_pc=0x100.
- Immediates: in_inst=0x2461FFFC -> opecode=0x09, imm_sext=0xFFFFFFFC, imm_zext=0x0000FFFC. in_inst=0x00221820 -> is_rtype=1, funct=0x20.
- Back-pressure: stream A,B,C with out_ready=0 from cycle 1.
  - A is held in main, B in skid, in_ready=0, C not accepted.
  - Raise out_ready: A, B, C are delivered in consecutive cycles, in_ready returns to 1.
  - Outputs stay stable during the stall.
- Throughput: 8 back-to-back instructions with out_ready=1 -> 8 consecutive out_valid cycles, order preserved, in_ready never drops.
- Flush: main and skid full, flush=1 with in_valid=1 (inst D).
  - Next cycle out_valid=0 and in_ready=1; D is never output.
  - The following input E is delivered normally.
- Async reset: assert rst mid-cycle while out_valid=1 -> out_valid=0 and in_ready=1 (after release) without a clock edge. All fields read 0.

Source files
------------

// File: rtl/inst_decode_stage.sv
// Registered instruction-decode stage: a main output register plus one skid entry,
// with every field output sliced straight from the main register's stored word.
module inst_decode_stage #(
    parameter int unsigned       INST_W    = 32,
    parameter int unsigned       OPC_W     = 6,
    parameter int unsigned       REG_W     = 5,
    parameter int unsigned       SHAMT_W   = 5,
    parameter int unsigned       FUNCT_W   = 6,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       PC_W      = 32,
    parameter logic [OPC_W-1:0]  RTYPE_OPC = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [INST_W-1:0]                 in_inst,
    input  logic [PC_W-1:0]                   in_pc,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PC_W-1:0]                   out_pc,
    output logic [OPC_W-1:0]                  opecode,
    output logic [REG_W-1:0]                  rd,
    output logic [REG_W-1:0]                  rs,
    output logic [REG_W-1:0]                  rt,
    output logic [SHAMT_W-1:0]                shamt,
    output logic [FUNCT_W-1:0]                funct,
    output logic [INST_W-OPC_W-2*REG_W-1:0]   immd,
    output logic [DATA_W-1:0]                 imm_sext,
    output logic [DATA_W-1:0]                 imm_zext,
    output logic [INST_W-OPC_W-1:0]           addr,
    output logic                              is_rtype
);

    localparam int unsigned IMM_W  = INST_W - OPC_W - 2 * REG_W;
    localparam int unsigned ADDR_W = INST_W - OPC_W;
    localparam int unsigned RD_LSB = INST_W - OPC_W - REG_W;
    localparam int unsigned RS_LSB = RD_LSB - REG_W;
    localparam int unsigned RT_LSB = RS_LSB - REG_W;

    // Reject field layouts that do not tile the instruction word exactly.
    if (OPC_W + 3 * REG_W + SHAMT_W + FUNCT_W != INST_W) begin : g_bad_fields
        $error("inst_decode_stage: field widths do not sum to INST_W");
    end
    if (DATA_W < IMM_W) begin : g_bad_data_w
        $error("inst_decode_stage: DATA_W must be at least IMM_W");
    end

    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   ready_d;
    logic   accept;
    logic   deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = main_q.valid && out_ready;

    // Next-state for the two entries; flush wins over accept and deliver.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!main_q.valid || deliver) begin
            if (skid_q.valid) begin
                main_d       = skid_q;
                skid_d.valid = accept;
                if (accept) begin
                    skid_d.inst = in_inst;
                    skid_d.pc   = in_pc;
                end
            end else if (accept) begin
                main_d.valid = 1'b1;
                main_d.inst  = in_inst;
                main_d.pc    = in_pc;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (accept) begin
            skid_d.valid = 1'b1;
            skid_d.inst  = in_inst;
            skid_d.pc    = in_pc;
        end
        ready_d = !skid_d.valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            in_ready <= 1'b1;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            in_ready <= ready_d;
        end
    end

    assign out_valid = main_q.valid;
    assign out_pc    = main_q.pc;
    assign opecode   = main_q.inst[INST_W-1 -: OPC_W];
    assign rd        = main_q.inst[RD_LSB +: REG_W];
    assign rs        = main_q.inst[RS_LSB +: REG_W];
    assign rt        = main_q.inst[RT_LSB +: REG_W];
    assign shamt     = main_q.inst[FUNCT_W +: SHAMT_W];
    assign funct     = main_q.inst[FUNCT_W-1:0];
    assign immd      = main_q.inst[IMM_W-1:0];
    assign imm_sext  = DATA_W'($signed(immd));
    assign imm_zext  = DATA_W'(immd);
    assign addr      = main_q.inst[ADDR_W-1:0];
    assign is_rtype  = (opecode == RTYPE_OPC);

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage: a decode vector table plus hand-written
// back-pressure, throughput, flush and async-reset sequences.
module tb_inst_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  opecode;
    logic [4:0]  rd, rs, rt, shamt;
    logic [5:0]  funct;
    logic [15:0] immd;
    logic [31:0] imm_sext, imm_zext;
    logic [25:0] addr;
    logic        is_rtype;

    int n_checks = 0;
    int n_fails  = 0;

    inst_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opecode(opecode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .funct(funct),
        .immd(immd), .imm_sext(imm_sext), .imm_zext(imm_zext), .addr(addr),
        .is_rtype(is_rtype)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [5:0]  opc;
        logic [4:0]  rd, rs, rt, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] sext, zext;
        logic [25:0] adr;
        logic        rtype;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    logic [31:0] held_pc;
    logic [5:0]  held_opc;
    logic [15:0] held_imm;

    initial begin
        vecs[0] = '{32'h28611020, 32'h100, 6'h0A, 5'd3, 5'd1, 5'd2, 5'd0, 6'h20,
                    16'h1020, 32'h00001020, 32'h00001020, 26'h0611020, 1'b0};
        vecs[1] = '{32'h2461FFFC, 32'h104, 6'h09, 5'd3, 5'd1, 5'd31, 5'd31, 6'h3C,
                    16'hFFFC, 32'hFFFFFFFC, 32'h0000FFFC, 26'h061FFFC, 1'b0};
        vecs[2] = '{32'h00221820, 32'h108, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20,
                    16'h1820, 32'h00001820, 32'h00001820, 26'h0221820, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F,
                    16'hFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 26'h3FFFFFF, 1'b0};
        vecs[4] = '{32'h8C0A8000, 32'h200, 6'h23, 5'd0, 5'd10, 5'd16, 5'd0, 6'h00,
                    16'h8000, 32'hFFFF8000, 32'h00008000, 26'h00A8000, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset opecode", 64'(opecode), 64'd0);
        check("reset out_pc", 64'(out_pc), 64'd0);

        // Decode table, one instruction at a time with out_ready high
        for (int i = 0; i < 5; i++) begin
            offer(vecs[i].inst, vecs[i].pc);
            tick();
            in_valid = 1'b0;
            check("vec out_valid", 64'(out_valid), 64'd1);
            check("vec out_pc", 64'(out_pc), 64'(vecs[i].pc));
            check("vec opecode", 64'(opecode), 64'(vecs[i].opc));
            check("vec rd", 64'(rd), 64'(vecs[i].rd));
            check("vec rs", 64'(rs), 64'(vecs[i].rs));
            check("vec rt", 64'(rt), 64'(vecs[i].rt));
            check("vec shamt", 64'(shamt), 64'(vecs[i].sh));
            check("vec funct", 64'(funct), 64'(vecs[i].fn));
            check("vec immd", 64'(immd), 64'(vecs[i].imm));
            check("vec imm_sext", 64'(imm_sext), 64'(vecs[i].sext));
            check("vec imm_zext", 64'(imm_zext), 64'(vecs[i].zext));
            check("vec addr", 64'(addr), 64'(vecs[i].adr));
            check("vec is_rtype", 64'(is_rtype), 64'(vecs[i].rtype));
        end
        tick();
        check("drain out_valid", 64'(out_valid), 64'd0);

        // Back-pressure: A in main, B in skid, C refused until space frees
        out_ready = 1'b0;
        offer(vecs[0].inst, 32'hA00);
        tick();
        offer(vecs[1].inst, 32'hB00);
        tick();
        check("bp in_ready low", 64'(in_ready), 64'd0);
        offer(vecs[2].inst, 32'hC00);
        held_pc = out_pc; held_opc = opecode; held_imm = immd;
        check("bp holds A", 64'(out_pc), 64'hA00);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp stable pc", 64'(out_pc), 64'(held_pc));
            check("bp stable opc", 64'(opecode), 64'(held_opc));
            check("bp stable imm", 64'(immd), 64'(held_imm));
            check("bp stall valid", 64'(out_valid), 64'd1);
            check("bp stall ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp B next", 64'(out_pc), 64'hB00);
        check("bp B opc", 64'(opecode), 64'h09);
        check("bp ready back", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp C next", 64'(out_pc), 64'hC00);
        check("bp C valid", 64'(out_valid), 64'd1);
        check("bp C rtype", 64'(is_rtype), 64'd1);
        tick();
        check("bp empty", 64'(out_valid), 64'd0);

        // Throughput: eight back-to-back instructions
        for (int i = 0; i < 8; i++) begin
            offer(32'h20000000 + 32'(i), 32'h1000 + 32'(4 * i));
            tick();
            check("tp out_valid", 64'(out_valid), 64'd1);
            check("tp order", 64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
            check("tp in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("tp drained", 64'(out_valid), 64'd0);

        // Flush with main and skid full, D offered alongside
        out_ready = 1'b0;
        offer(vecs[0].inst, 32'h300);
        tick();
        offer(vecs[1].inst, 32'h304);
        tick();
        check("fl skid full", 64'(in_ready), 64'd0);
        offer(vecs[2].inst, 32'hD00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl out_valid", 64'(out_valid), 64'd0);
        check("fl in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        check("fl D never", 64'(out_valid), 64'd0);
        // Flush while ready: offered input is still dropped
        offer(vecs[2].inst, 32'hD04);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl drop ready", 64'(out_valid), 64'd0);
        offer(vecs[3].inst, 32'hE00);
        tick();
        in_valid = 1'b0;
        check("fl E valid", 64'(out_valid), 64'd1);
        check("fl E pc", 64'(out_pc), 64'hE00);
        check("fl E opc", 64'(opecode), 64'h3F);
        tick();

        // Async reset between edges while holding data
        out_ready = 1'b0;
        offer(vecs[0].inst, 32'h400);
        tick();
        offer(vecs[1].inst, 32'h404);
        tick();
        in_valid = 1'b0;
        check("ar pre valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar out_valid", 64'(out_valid), 64'd0);
        check("ar opecode", 64'(opecode), 64'd0);
        check("ar out_pc", 64'(out_pc), 64'd0);
        check("ar imm_zext", 64'(imm_zext), 64'd0);
        check("ar addr", 64'(addr), 64'd0);
        #1;
        rst = 1'b0;
        #1;
        check("ar in_ready", 64'(in_ready), 64'd1);
        tick();
        check("ar stays empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
